run_ctrl: RTL and testbench
===========================

// Module: run_ctrl
// PURPOSE
//  Core run-control unit inside top. It sequences the three benchmark programs in one run:
//   mpy (P0), pattern search (P1) and closest pair (P2).
//  Per program it loads the PC with that program's start address, lets the core run until
//   the halt instruction retires, then signals completion on done.
//  It then auto-launches the next program, which makes it the DUT-side responder to the
//   bench's reset/done handshake.
//  A per-program watchdog stops runaway code.
// PARAMETERS
//  PC_W      10    program counter width
//  CNT_W     16    cycle counter / watchdog width
//  START_P0  0     P0 start address
//  START_P1  128   P1 start address
//  START_P2  512   P2 start address
//  DONE_HOLD 4     cycles done is held high between programs (>=2)
//  TIMEOUT   60000 max RUN cycles per program before forced stop
// PORTS
//  clk          in   1      core clock, rising edge
//  reset        in   1      async, active-high; clears all state
//  halt         in   1      from decoder, 1-cycle pulse when halt instr retires
//  run_en       out  1      core fetch/commit enable
//  pc_load      out  1      1-cycle pulse: PC <= pc_init
//  pc_init      out  PC_W   start address of current program
//  done         out  1      program complete (to top.done)
//  prog_idx     out  2      current program 0..2
//  timeout      out  1      last program ended by watchdog
//  cycle_count  out  CNT_W  RUN cycles of current/last program
// BEHAVIOUR
//  Reset (async assert, sync release) values:
//   state=IDLE, run_en=0, pc_load=0, pc_init=START_P0, done=0, prog_idx=0, timeout=0,
//   cycle_count=0.
//  Reset mid-operation in any state aborts immediately to these values. P0 restarts.
//  FSM, one transition per rising clk edge:
//   IDLE: outputs idle. Next edge -> LAUNCH. This gives 1 cycle of settle after reset release.
//   LAUNCH: pc_load=1, pc_init=START_P<prog_idx>, run_en=0. cycle_count<=0, timeout<=0.
//    Next edge -> RUN.
//   RUN: run_en=1. cycle_count increments each RUN cycle, including the halt cycle.
//    halt=1 -> DONE.
//    Else cycle_count==TIMEOUT-1 -> DONE with timeout<=1.
//    halt and watchdog limit in the same cycle: halt wins, timeout stays 0.
//   DONE: done=1, run_en=0, hold counter counts 0..DONE_HOLD-1.
//    At DONE_HOLD-1: prog_idx==2 -> FINISHED. Else prog_idx++ and -> LAUNCH.
//    done drops in LAUNCH, so the bench sees a clean done pulse per program.
//   FINISHED: done=1 sticky, run_en=0. Leaves only on reset.
//  halt is ignored outside RUN. pc_load is never high in two consecutive cycles.
//  Latency:
//   halt sampled at edge N -> done high from N, for exactly DONE_HOLD cycles.
//   pc_load for the next program follows at N+DONE_HOLD.
//  cycle_count and timeout hold their value through DONE/FINISHED for bench readout.
//  cycle_count saturates at TIMEOUT-1. There is no wrap.
//  All outputs are registered or decoded from registered state only. No input→output comb path.
// STRUCTURE
//  run_ctrl_pkg:
//   typedef enum logic[2:0] {IDLE, LAUNCH, RUN, DONE, FINISHED} rc_state_t
//   NPROG=3 constant
//   prog_idx_t
//  One sub-module: run_watchdog.
//   Holds the CNT_W counter with clear/enable/saturate and the limit-hit flag.
//  run_ctrl holds the FSM, the hold counter, prog_idx and the start-address mux.
// TESTING
//  1. reset 1->0, no halt
//     -> IDLE 1 cyc, pc_load pulse with pc_init=0, run_en=1 on next cycle.
//  2. halt after 10 RUN cycles
//     -> cycle_count=10, done=1 for 4 cyc, then pc_load with pc_init=128, prog_idx=1.
//  3. halts on all of P0, P1, P2
//     -> three done pulses. After the third, done stays 1, prog_idx=2, run_en=0 indefinitely.
//  4. TIMEOUT=50, no halt
//     -> DONE at cycle_count=49, timeout=1. Next program launches with timeout cleared.
//  5. halt on the exact watchdog-limit cycle
//     -> timeout=0, normal DONE.
//     Also: halt pulses during LAUNCH/DONE are ignored.
//  6. reset asserted mid-RUN of P1 (async, between edges)
//     -> outputs return to reset values immediately. After release, P0 (addr 0) relaunches.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run-control unit.
//   rc_state_t : run-control FSM states
//   NPROG      : number of benchmark programs sequenced per run
//   prog_idx_t : program index type (0..NPROG-1)
package run_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, FINISHED} rc_state_t;

  localparam int NPROG = 3;

  typedef logic [1:0] prog_idx_t;

endpackage

// File: rtl/run_watchdog.sv
// run_watchdog: per-program RUN-cycle counter and watchdog limit detect.
//   clk, rst  : clock, async active-high reset
//   clr_i     : synchronous clear (takes priority over en_i)
//   en_i      : count one RUN cycle
//   count_o   : current count, saturates at TIMEOUT-1
//   limit_o   : count_o has reached TIMEOUT-1
module run_watchdog #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 60000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             limit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)                  count_d = '0;
    else if (en_i && !limit_o)  count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign limit_o = (count_q == LIMIT);
  assign count_o = count_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences the three benchmark programs (P0 mpy, P1 pattern
// search, P2 closest pair). Per program: load PC, run until halt retires
// (or the watchdog expires), hold done for DONE_HOLD cycles, then launch
// the next program. After P2, done stays high until reset.
//   clk, reset  : clock, async active-high reset
//   halt        : 1-cycle pulse when the halt instruction retires
//   run_en      : core fetch/commit enable
//   pc_load     : 1-cycle pulse, PC <= pc_init
//   pc_init     : start address of the current program
//   done        : program complete
//   prog_idx    : current program 0..2
//   timeout     : last program was stopped by the watchdog
//   cycle_count : RUN cycles of the current/last program
// All outputs come from registered state only.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int CNT_W     = 16,
  parameter int START_P0  = 0,
  parameter int START_P1  = 128,
  parameter int START_P2  = 512,
  parameter int DONE_HOLD = 4,
  parameter int TIMEOUT   = 60000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  output logic             run_en,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_init,
  output logic             done,
  output logic [1:0]       prog_idx,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HOLD_W = (DONE_HOLD > 2) ? $clog2(DONE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);
  localparam prog_idx_t         LAST_PROG = prog_idx_t'(NPROG - 1);

  rc_state_t         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  prog_idx_t         idx_q, idx_d;
  logic              to_q, to_d;
  logic              wd_limit;

  run_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (state_q == LAUNCH),
    .en_i    (state_q == RUN),
    .count_o (cycle_count),
    .limit_o (wd_limit)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    to_d    = to_q;
    case (state_q)
      IDLE:   state_d = LAUNCH;
      LAUNCH: begin
        to_d    = 1'b0;
        hold_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        // halt beats the watchdog when both land in the same cycle
        if (halt) begin
          state_d = DONE;
        end else if (wd_limit) begin
          state_d = DONE;
          to_d    = 1'b1;
        end
      end
      DONE: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (idx_q == LAST_PROG) begin
            state_d = FINISHED;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LAUNCH;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      FINISHED: state_d = FINISHED;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    pc_init = PC_W'(START_P0);
      2'd1:    pc_init = PC_W'(START_P1);
      default: pc_init = PC_W'(START_P2);
    endcase
  end

  assign run_en   = (state_q == RUN);
  assign pc_load  = (state_q == LAUNCH);
  assign done     = (state_q == DONE) || (state_q == FINISHED);
  assign prog_idx = idx_q;
  assign timeout  = to_q;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam int PC_W = 10, CNT_W = 16, HOLD = 4, TMO = 50;

  logic             clk = 1'b0;
  logic             reset, halt;
  logic             run_en, pc_load, done, timeout;
  logic [PC_W-1:0]  pc_init;
  logic [1:0]       prog_idx;
  logic [CNT_W-1:0] cycle_count;

  typedef struct {
    int cnt;
    int to;
    int idx;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .START_P0(0), .START_P1(128), .START_P2(512),
    .DONE_HOLD(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .halt(halt), .run_en(run_en), .pc_load(pc_load),
    .pc_init(pc_init), .done(done), .prog_idx(prog_idx), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".run_en"}, run_en, 0);
    chk({tag, ".pc_load"}, pc_load, 0);
    chk({tag, ".pc_init"}, pc_init, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".prog_idx"}, prog_idx, 0);
    chk({tag, ".timeout"}, timeout, 0);
    chk({tag, ".cycle_count"}, cycle_count, 0);
  endtask

  // Wait (bounded) for pc_load, check the address, step into RUN cycle 1.
  // Optionally pulse halt during LAUNCH; it must be ignored.
  task automatic wait_launch(input int exp_pc, input int exp_idx, input bit halt_in_launch);
    int n = 0;
    while (pc_load !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("launch.seen", pc_load, 1);
    chk("launch.pc_init", pc_init, exp_pc);
    chk("launch.prog_idx", prog_idx, exp_idx);
    chk("launch.run_en", run_en, 0);
    if (halt_in_launch) halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("run1.run_en", run_en, 1);
    chk("run1.pc_load", pc_load, 0);
    chk("run1.timeout", timeout, 0);
    chk("run1.cycle_count", cycle_count, 0);
  endtask

  // Called at the negedge of RUN cycle 1; halt retires in RUN cycle n.
  task automatic run_halt(input int n, input int exp_cnt, input int idx);
    exp_t e;
    for (int k = 1; k < n; k++) @(negedge clk);
    halt = 1'b1;
    e.cnt = exp_cnt; e.to = 0; e.idx = idx;
    sb.push_back(e);
    @(negedge clk);
    halt = 1'b0;
  endtask

  // No halt: the watchdog must end the program.
  task automatic run_timeout(input int idx);
    exp_t e;
    int n = 0;
    e.cnt = TMO - 1; e.to = 1; e.idx = idx;
    sb.push_back(e);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo.run_cycles", n, TMO);
  endtask

  // Called in the first DONE cycle: compare against scoreboard, measure hold.
  task automatic check_done(input bit last, input bit halt_in_done);
    exp_t e;
    int h = 0;
    chk("done.rise", done, 1);
    chk("done.run_en", run_en, 0);
    if (sb.size() == 0) begin
      chk("done.sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("done.cycle_count", cycle_count, e.cnt);
      chk("done.timeout", timeout, e.to);
      chk("done.prog_idx", prog_idx, e.idx);
    end
    while (done === 1'b1 && h < 20) begin
      if (halt_in_done && h == 1) halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      h++;
      if (done === 1'b1 && e.cnt >= 0) chk("done.hold_count_stable", cycle_count, e.cnt);
    end
    if (last) begin
      chk("fin.done_sticky", done, 1);
      chk("fin.run_en", run_en, 0);
      chk("fin.pc_load", pc_load, 0);
      chk("fin.prog_idx", prog_idx, 2);
    end else begin
      chk("done.hold_len", h, HOLD);
      chk("done.then_launch", pc_load, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    halt  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // Run A: normal halt, timeout, halt on watchdog-limit cycle
    reset = 1'b0;
    chk("idle.pc_load", pc_load, 0);
    @(negedge clk);
    wait_launch(0, 0, 1'b0);
    run_halt(10, 10, 0);
    check_done(1'b0, 1'b1);
    wait_launch(128, 1, 1'b1);
    run_timeout(1);
    check_done(1'b0, 1'b0);
    wait_launch(512, 2, 1'b0);
    run_halt(TMO, TMO - 1, 2);
    check_done(1'b1, 1'b1);

    // Run B: three plain halts after a fresh reset
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst2");
    reset = 1'b0;
    @(negedge clk);
    wait_launch(0, 0, 1'b0);
    run_halt(2, 2, 0);
    check_done(1'b0, 1'b0);
    wait_launch(128, 1, 1'b0);
    run_halt(7, 7, 1);
    check_done(1'b0, 1'b0);
    wait_launch(512, 2, 1'b0);
    run_halt(1, 1, 2);
    check_done(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("fin.long_done", done, 1);
    chk("fin.long_run_en", run_en, 0);

    // Run C: async reset in the middle of P1's RUN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wait_launch(0, 0, 1'b0);
    run_halt(3, 3, 0);
    check_done(1'b0, 1'b0);
    wait_launch(128, 1, 1'b0);
    repeat (4) @(negedge clk);
    chk("midrun.run_en", run_en, 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wait_launch(0, 0, 1'b0);
    chk("sb.drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
